// File: rtl/rpn_stack_ctrl_if.sv
// rpn_stack_ctrl_if: token input, stack master and result/status signals of rpn_stack_ctrl.
// The slave modport is the sequencer's view; master is the environment that drives tokens and models the stack.
interface rpn_stack_ctrl_if #(
    parameter int DEPTH = 8,
    parameter int CW    = $clog2(DEPTH + 1)
);
    logic          tok_valid;
    logic          tok_ready;
    logic          tok_is_op;
    logic [7:0]    tok_data;
    logic          stk_push;
    logic          stk_pop;
    logic [7:0]    stk_din;
    logic [7:0]    stk_dout;
    logic          stk_empty;
    logic          stk_full;
    logic          res_valid;
    logic [7:0]    res_data;
    logic [CW-1:0] count;
    logic          err_ovf;
    logic          err_unf;
    logic          err_op;

    modport slave (
        input  tok_valid, tok_is_op, tok_data, stk_dout, stk_empty, stk_full,
        output tok_ready, stk_push, stk_pop, stk_din, res_valid, res_data,
               count, err_ovf, err_unf, err_op
    );

    modport master (
        output tok_valid, tok_is_op, tok_data, stk_dout, stk_empty, stk_full,
        input  tok_ready, stk_push, stk_pop, stk_din, res_valid, res_data,
               count, err_ovf, err_unf, err_op
    );
endinterface

// File: rtl/rpn_stack_ctrl.sv
// rpn_stack_ctrl: RPN token sequencer, sole master of an external DEPTH-entry byte LIFO.
// Build option RPN_MUL_EN: opcode 7 is MUL when defined, otherwise it is an illegal opcode (err_op).
module rpn_stack_ctrl #(
    parameter int DEPTH = 8,
    parameter int CW    = $clog2(DEPTH + 1)
) (
    input  logic            clk,
    input  logic            rst,
    rpn_stack_ctrl_if.slave bus
);
    typedef enum logic [2:0] {IDLE, PUSH, POP1, CAP1, POP2, CAP2, PUSHR, PUSH2} state_t;
    typedef enum logic [2:0] {OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_DUP, OP_DROP, OP_MUL} opcode_t;

    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
    localparam logic [CW-1:0] TWO_CNT  = CW'(2);
    localparam logic [CW-1:0] ONE_CNT  = CW'(1);

    state_t        state_q, state_d;
    opcode_t       op_q, op_d;
    logic [7:0]    b_q, b_d;
    logic [7:0]    din_q, din_d;
    logic [7:0]    res_q, res_d;
    logic [CW-1:0] count_q, count_d;
    logic          ovf_q, ovf_d;
    logic          unf_q, unf_d;
    logic          operr_q, operr_d;

    logic          tok_ready;
    logic          push;
    logic          pop;
    logic          res_valid;
    opcode_t       tok_op;

    function automatic logic [7:0] alu(input opcode_t op, input logic [7:0] a, input logic [7:0] b);
        logic [7:0] r;
        r = '0;
        case (op)
            OP_ADD:  r = a + b;
            OP_SUB:  r = a - b;
            OP_AND:  r = a & b;
            OP_OR:   r = a | b;
            OP_XOR:  r = a ^ b;
`ifdef RPN_MUL_EN
            OP_MUL:  r = a * b;
`endif
            default: r = '0;
        endcase
        return r;
    endfunction

    assign tok_op = opcode_t'(bus.tok_data[2:0]);

    always_comb begin
        state_d   = state_q;
        op_d      = op_q;
        b_d       = b_q;
        din_d     = din_q;
        res_d     = res_q;
        count_d   = count_q;
        ovf_d     = ovf_q;
        unf_d     = unf_q;
        operr_d   = operr_q;
        tok_ready = 1'b0;
        push      = 1'b0;
        pop       = 1'b0;
        res_valid = 1'b0;

        case (state_q)
            IDLE: begin
                tok_ready = 1'b1;
                // count is authoritative; the stack's own flags only flag disagreement
                if (bus.stk_full != (count_q == FULL_CNT)) ovf_d = 1'b1;
                if (bus.stk_empty != (count_q == '0))      unf_d = 1'b1;
                if (bus.tok_valid) begin
                    if (!bus.tok_is_op) begin
                        if (count_q < FULL_CNT) begin
                            din_d   = bus.tok_data;
                            state_d = PUSH;
                        end else begin
                            ovf_d = 1'b1;
                        end
                    end else begin
                        op_d = tok_op;
                        case (tok_op)
                            OP_DUP: begin
                                if (count_q == '0)            unf_d   = 1'b1;
                                else if (count_q == FULL_CNT) ovf_d   = 1'b1;
                                else                          state_d = POP1;
                            end
                            OP_DROP: begin
                                if (count_q == '0) unf_d   = 1'b1;
                                else               state_d = POP1;
                            end
`ifndef RPN_MUL_EN
                            OP_MUL: operr_d = 1'b1;
`endif
                            default: begin
                                if (count_q < TWO_CNT) unf_d   = 1'b1;
                                else                   state_d = POP1;
                            end
                        endcase
                    end
                end
            end
            PUSH: begin
                push    = 1'b1;
                count_d = count_q + ONE_CNT;
                state_d = IDLE;
            end
            POP1: begin
                pop     = 1'b1;
                count_d = count_q - ONE_CNT;
                state_d = (op_q == OP_DROP) ? IDLE : CAP1;
            end
            CAP1: begin
                b_d = bus.stk_dout;
                if (op_q == OP_DUP) begin
                    din_d   = bus.stk_dout;
                    state_d = PUSHR;
                end else begin
                    state_d = POP2;
                end
            end
            POP2: begin
                pop     = 1'b1;
                count_d = count_q - ONE_CNT;
                state_d = CAP2;
            end
            CAP2: begin
                // result registered here so res_data is already valid alongside res_valid
                res_d   = alu(op_q, bus.stk_dout, b_q);
                din_d   = alu(op_q, bus.stk_dout, b_q);
                state_d = PUSHR;
            end
            PUSHR: begin
                push      = 1'b1;
                count_d   = count_q + ONE_CNT;
                res_valid = (op_q != OP_DUP);
                state_d   = (op_q == OP_DUP) ? PUSH2 : IDLE;
            end
            PUSH2: begin
                push    = 1'b1;
                count_d = count_q + ONE_CNT;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            op_q    <= OP_ADD;
            b_q     <= '0;
            din_q   <= '0;
            res_q   <= '0;
            count_q <= '0;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
            operr_q <= 1'b0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            b_q     <= b_d;
            din_q   <= din_d;
            res_q   <= res_d;
            count_q <= count_d;
            ovf_q   <= ovf_d;
            unf_q   <= unf_d;
            operr_q <= operr_d;
        end
    end

    assign bus.tok_ready = tok_ready;
    assign bus.stk_push  = push;
    assign bus.stk_pop   = pop;
    assign bus.stk_din   = din_q;
    assign bus.res_valid = res_valid;
    assign bus.res_data  = res_q;
    assign bus.count     = count_q;
    assign bus.err_ovf   = ovf_q;
    assign bus.err_unf   = unf_q;
    assign bus.err_op    = operr_q;
endmodule

// File: tb/tb_rpn_stack_ctrl.sv
// tb_rpn_stack_ctrl: directed vector table, corner sequences and random tokens checked against a queue-based RPN model.
// A behavioural LIFO stands in for the attached stack.
module tb_rpn_stack_ctrl;
    localparam int DEPTH = 8;
    localparam int CW    = $clog2(DEPTH + 1);

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    rpn_stack_ctrl_if #(.DEPTH(DEPTH), .CW(CW)) bus ();
    rpn_stack_ctrl #(.DEPTH(DEPTH), .CW(CW)) dut (.clk(clk), .rst(rst), .bus(bus));

    logic [7:0] mem [DEPTH];
    int         sp;
    logic [7:0] dout_q;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            sp     <= 0;
            dout_q <= '0;
        end else if (bus.stk_push && sp < DEPTH) begin
            mem[3'(sp)] <= bus.stk_din;
            sp          <= sp + 1;
        end else if (bus.stk_pop && sp > 0) begin
            dout_q <= mem[3'(sp - 1)];
            sp     <= sp - 1;
        end
    end
    assign bus.stk_dout  = dout_q;
    assign bus.stk_empty = (sp == 0);
    assign bus.stk_full  = (sp == DEPTH);

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        bus.tok_valid = 1'b0;
        bus.tok_is_op = 1'b0;
        bus.tok_data  = '0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic check_reset(input string tag);
        chk({tag, "_tok_ready"}, bus.tok_ready, 1);
        chk({tag, "_stk_push"},  bus.stk_push, 0);
        chk({tag, "_stk_pop"},   bus.stk_pop, 0);
        chk({tag, "_stk_din"},   bus.stk_din, 0);
        chk({tag, "_res_valid"}, bus.res_valid, 0);
        chk({tag, "_res_data"},  bus.res_data, 0);
        chk({tag, "_count"},     bus.count, 0);
        chk({tag, "_errs"},      {bus.err_ovf, bus.err_unf, bus.err_op}, 0);
    endtask

    task automatic send_tok(input bit is_op, input logic [7:0] d,
                            output int busy, output int npush, output int npop,
                            output int nres, output logic [7:0] lastres);
        busy = 0; npush = 0; npop = 0; nres = 0; lastres = '0;
        @(negedge clk);
        chk("tok_ready_idle", bus.tok_ready, 1);
        bus.tok_valid = 1'b1;
        bus.tok_is_op = is_op;
        bus.tok_data  = d;
        #1;
        if (bus.stk_push) npush++;
        if (bus.stk_pop)  npop++;
        @(negedge clk);
        bus.tok_valid = 1'b0;
        bus.tok_is_op = 1'b0;
        bus.tok_data  = '0;
        while (!bus.tok_ready && busy < 20) begin
            busy++;
            chk("push_pop_excl", bus.stk_push & bus.stk_pop, 0);
            if (bus.stk_push) npush++;
            if (bus.stk_pop)  npop++;
            if (bus.res_valid) begin
                nres++;
                lastres = bus.res_data;
            end
            @(negedge clk);
        end
        if (busy >= 20) chk("busy_timeout", busy, 0);
    endtask

    typedef struct {
        bit         is_op;
        logic [7:0] data;
        int         busy;
        int         count;
        int         nres;
        logic [7:0] res;
        bit         ovf;
        bit         unf;
        bit         op;
        bit         has_dout;
        logic [7:0] dout;
    } vec_t;
    vec_t tv[$];

    // Reference: plain RPN evaluation on a queue, back of queue is top of stack
    logic [7:0] mq[$];
    bit         m_ovf, m_unf, m_op;
    logic [7:0] m_res;

    function automatic logic [7:0] ref_calc(input int op, input int a, input int b);
        case (op)
            0: return 8'((a + b) % 256);
            1: return 8'((a - b + 256) % 256);
            2: return 8'(a & b);
            3: return 8'(a | b);
            4: return 8'(a ^ b);
            7: return 8'((a * b) % 256);
            default: return 8'h00;
        endcase
    endfunction

    task automatic model_tok(input bit is_op, input logic [7:0] d,
                             output int e_busy, output int e_push, output int e_pop, output int e_nres);
        int op;
        logic [7:0] a, b;
        e_busy = 0; e_push = 0; e_pop = 0; e_nres = 0;
        op = int'(d[2:0]);
        if (!is_op) begin
            if (mq.size() < DEPTH) begin
                mq.push_back(d);
                e_busy = 1; e_push = 1;
            end else m_ovf = 1'b1;
        end else if (op == 5) begin
            if (mq.size() == 0) m_unf = 1'b1;
            else if (mq.size() == DEPTH) m_ovf = 1'b1;
            else begin
                mq.push_back(mq[$]);
                e_busy = 4; e_push = 2; e_pop = 1;
            end
        end else if (op == 6) begin
            if (mq.size() == 0) m_unf = 1'b1;
            else begin
                void'(mq.pop_back());
                e_busy = 1; e_pop = 1;
            end
`ifndef RPN_MUL_EN
        end else if (op == 7) begin
            m_op = 1'b1;
`endif
        end else begin
            if (mq.size() < 2) m_unf = 1'b1;
            else begin
                b = mq.pop_back();
                a = mq.pop_back();
                m_res = ref_calc(op, int'(a), int'(b));
                mq.push_back(m_res);
                e_busy = 5; e_push = 1; e_pop = 2; e_nres = 1;
            end
        end
    endtask

    int         busy, npush, npop, nres;
    int         e_busy, e_push, e_pop, e_nres;
    logic [7:0] lastres;
    bit         r_is_op;
    logic [7:0] r_data;

    initial begin
        bus.tok_valid = 1'b0;
        bus.tok_is_op = 1'b0;
        bus.tok_data  = '0;
        do_reset();
        check_reset("reset");

        tv.push_back('{0, 8'h11, 1, 1, 0, 8'h00, 0, 0, 0, 0, 8'h00});
        tv.push_back('{0, 8'h22, 1, 2, 0, 8'h00, 0, 0, 0, 0, 8'h00});
        tv.push_back('{1, 8'h00, 5, 1, 1, 8'h33, 0, 0, 0, 0, 8'h00});
        tv.push_back('{1, 8'h06, 1, 0, 0, 8'h33, 0, 0, 0, 1, 8'h33});
        tv.push_back('{0, 8'h03, 1, 1, 0, 8'h33, 0, 0, 0, 0, 8'h00});
        tv.push_back('{0, 8'h05, 1, 2, 0, 8'h33, 0, 0, 0, 0, 8'h00});
        tv.push_back('{1, 8'h01, 5, 1, 1, 8'hFE, 0, 0, 0, 0, 8'h00});
        tv.push_back('{1, 8'h06, 1, 0, 0, 8'hFE, 0, 0, 0, 1, 8'hFE});
        tv.push_back('{1, 8'h00, 0, 0, 0, 8'hFE, 0, 1, 0, 0, 8'h00});
        tv.push_back('{0, 8'h44, 1, 1, 0, 8'hFE, 0, 1, 0, 0, 8'h00});
        tv.push_back('{1, 8'h05, 4, 2, 0, 8'hFE, 0, 1, 0, 0, 8'h00});
        tv.push_back('{1, 8'h04, 5, 1, 1, 8'h00, 0, 1, 0, 0, 8'h00});
        tv.push_back('{1, 8'h06, 1, 0, 0, 8'h00, 0, 1, 0, 1, 8'h00});
        tv.push_back('{0, 8'h04, 1, 1, 0, 8'h00, 0, 1, 0, 0, 8'h00});
        tv.push_back('{0, 8'h06, 1, 2, 0, 8'h00, 0, 1, 0, 0, 8'h00});
`ifdef RPN_MUL_EN
        tv.push_back('{1, 8'h07, 5, 1, 1, 8'h18, 0, 1, 0, 0, 8'h00});
`else
        tv.push_back('{1, 8'h07, 0, 2, 0, 8'h00, 0, 1, 1, 0, 8'h00});
`endif

        foreach (tv[i]) begin
            send_tok(tv[i].is_op, tv[i].data, busy, npush, npop, nres, lastres);
            chk($sformatf("vec%0d_busy", i), busy, tv[i].busy);
            chk($sformatf("vec%0d_count", i), bus.count, tv[i].count);
            chk($sformatf("vec%0d_nres", i), nres, tv[i].nres);
            if (tv[i].nres > 0) chk($sformatf("vec%0d_lastres", i), lastres, tv[i].res);
            chk($sformatf("vec%0d_res_data", i), bus.res_data, tv[i].res);
            chk($sformatf("vec%0d_errs", i), {bus.err_ovf, bus.err_unf, bus.err_op},
                {tv[i].ovf, tv[i].unf, tv[i].op});
            if (tv[i].has_dout) chk($sformatf("vec%0d_popped", i), bus.stk_dout, tv[i].dout);
        end

        // Fill to capacity, then one more operand must be dropped
        do_reset();
        for (int i = 0; i < DEPTH; i++) begin
            send_tok(1'b0, 8'(8'h10 + i), busy, npush, npop, nres, lastres);
            chk($sformatf("fill%0d_count", i), bus.count, i + 1);
        end
        send_tok(1'b0, 8'h99, busy, npush, npop, nres, lastres);
        chk("ovf_flag", bus.err_ovf, 1);
        chk("ovf_count", bus.count, DEPTH);
        chk("ovf_npush", npush, 0);
        chk("ovf_busy", busy, 0);
        chk("ovf_top", mem[3'(DEPTH - 1)], 8'h17);
        chk("ovf_unf_op", {bus.err_unf, bus.err_op}, 0);

        // Reset while an ADD sits in CAP1
        do_reset();
        send_tok(1'b0, 8'h11, busy, npush, npop, nres, lastres);
        send_tok(1'b0, 8'h22, busy, npush, npop, nres, lastres);
        @(negedge clk);
        bus.tok_valid = 1'b1;
        bus.tok_is_op = 1'b1;
        bus.tok_data  = 8'h00;
        @(negedge clk);
        bus.tok_valid = 1'b0;
        chk("midrst_in_pop1", bus.stk_pop, 1);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check_reset("midrst");
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("midrst_ready", bus.tok_ready, 1);
        send_tok(1'b0, 8'h55, busy, npush, npop, nres, lastres);
        chk("midrst_after_count", bus.count, 1);
        chk("midrst_after_top", mem[0], 8'h55);

        // Random token stream against the reference model
        do_reset();
        mq.delete();
        m_ovf = 1'b0; m_unf = 1'b0; m_op = 1'b0; m_res = '0;
        for (int n = 0; n < 400; n++) begin
            r_is_op = ($urandom_range(0, 99) < 50);
            r_data  = 8'($urandom);
            model_tok(r_is_op, r_data, e_busy, e_push, e_pop, e_nres);
            send_tok(r_is_op, r_data, busy, npush, npop, nres, lastres);
            chk($sformatf("rnd%0d_busy", n), busy, e_busy);
            chk($sformatf("rnd%0d_npush", n), npush, e_push);
            chk($sformatf("rnd%0d_npop", n), npop, e_pop);
            chk($sformatf("rnd%0d_nres", n), nres, e_nres);
            if (e_nres > 0) chk($sformatf("rnd%0d_lastres", n), lastres, m_res);
            chk($sformatf("rnd%0d_res_data", n), bus.res_data, m_res);
            chk($sformatf("rnd%0d_count", n), bus.count, mq.size());
            chk($sformatf("rnd%0d_depth", n), sp, mq.size());
            if (mq.size() > 0) chk($sformatf("rnd%0d_top", n), mem[3'(sp - 1)], mq[$]);
            chk($sformatf("rnd%0d_errs", n), {bus.err_ovf, bus.err_unf, bus.err_op}, {m_ovf, m_unf, m_op});
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got sim time limit expected completion");
        $fatal(1);
    end
endmodule
